// File: rtl/win3x3_gen_pkg.sv
// Purpose : shared constants and types for the 3x3 window generator.
// Latency : n/a (package only).
// Backpres: n/a (package only).
//
// Window packing: tap (row, col) of the 3x3 window occupies slot tap_slot(row, col),
// i.e. bits [slot*DATA_WIDTH +: DATA_WIDTH]. p00 lands in the MSBs, p22 in the LSBs.
package win3x3_gen_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int NUM_TAPS       = 9;

    // Row-major, p00 first (highest slot).
    function automatic int tap_slot(input int row, input int col);
        return (NUM_TAPS - 1) - (row * 3 + col);
    endfunction

    // Marker bundle registered alongside each window.
    typedef struct packed {
        logic sof;
        logic sol;
        logic eol;
        logic eof;
    } win_mark_t;

endpackage

// File: rtl/win3x3_gen_line_buf.sv
// Purpose : one line of pixel storage, simple dual port, async read / sync write.
// Latency : read is combinational, write lands on the next clk edge.
// Backpres: none; caller gates we.
//
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
// Contents are intentionally not reset.
module win3x3_gen_line_buf #(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/win3x3_gen.sv
// Purpose : turns a 1 pixel/cycle raster stream into one 3x3 window per interior pixel.
// Latency : 1 cycle from accepting pixel (r,c) to its window on win_data.
// Backpres: single output register; in_rdy = ~win_val | win_rdy, so input stalls while a window waits.
//
// Ports: clk, rst (async, active high);
//        in_val/in_rdy/in_data/in_sof/in_sol/in_eol/in_eof  upstream pixel stream;
//        win_val/win_rdy/win_data/win_sof/win_sol/win_eol/win_eof  window stream;
//        err_ovf  sticky flag, set when a line runs past MAX_WIDTH.
module win3x3_gen
    import win3x3_gen_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_WIDTH  = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_val,
    output logic                    in_rdy,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_sof,
    input  logic                    in_sol,
    input  logic                    in_eol,
    input  logic                    in_eof,
    output logic                    win_val,
    input  logic                    win_rdy,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic                    win_sof,
    output logic                    win_sol,
    output logic                    win_eol,
    output logic                    win_eof,
    output logic                    err_ovf
);

    // One extra column bit so "past the end of the line buffer" is representable.
    localparam int             CW    = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]  C_MAX = CW'(MAX_WIDTH);
    localparam logic [CW-1:0]  C_ONE = CW'(1);
    localparam logic [CW-1:0]  C_TWO = CW'(2);
    localparam logic [15:0]    R_ONE = 16'd1;
    localparam logic [15:0]    R_TWO = 16'd2;

    logic                  accept;
    logic                  synced;   // seen an sof since reset
    logic                  live;     // accepted pixel belongs to a tracked frame
    logic                  in_range;
    logic                  emit;
    logic [CW-1:0]         col;
    logic [15:0]           row;
    logic [CW-1:0]         c;
    logic [15:0]           r;
    logic [DATA_WIDTH-1:0] lb0_rd;
    logic [DATA_WIDTH-1:0] lb1_rd;
    logic [DATA_WIDTH-1:0] lb0_q;
    logic [DATA_WIDTH-1:0] lb1_q;
    logic [DATA_WIDTH-1:0] sr     [3][3];
    logic [DATA_WIDTH-1:0] sr_nxt [3][3];
    logic [9*DATA_WIDTH-1:0] win_nxt;
    win_mark_t             mark_nxt;
    win_mark_t             mark_q;

    assign in_rdy = ~win_val | win_rdy;
    assign accept = in_val & in_rdy;
    // Pixels before the first sof are swallowed without touching any state.
    assign live   = accept & (synced | in_sof);

    // Coordinate of the pixel currently on the input.
    assign c = (in_sof | in_sol) ? '0 : col;
    assign r = in_sof ? '0 : (in_sol ? row + R_ONE : row);

    assign in_range = (c < C_MAX);
    assign emit     = live & in_range & (r >= R_TWO) & (c >= C_TWO);

    // lb0 holds row r-1, lb1 holds row r-2; both roll forward one line per write.
    win3x3_gen_line_buf #(
        .DEPTH      (MAX_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lb0 (
        .clk   (clk),
        .we    (live & in_range),
        .waddr (c[ADDR_WIDTH-1:0]),
        .wdata (in_data),
        .raddr (c[ADDR_WIDTH-1:0]),
        .rdata (lb0_rd)
    );

    win3x3_gen_line_buf #(
        .DEPTH      (MAX_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lb1 (
        .clk   (clk),
        .we    (live & in_range),
        .waddr (c[ADDR_WIDTH-1:0]),
        .wdata (lb0_rd),
        .raddr (c[ADDR_WIDTH-1:0]),
        .rdata (lb1_rd)
    );

    // Out-of-range addresses may exceed the RAM depth; never let that reach the taps.
    assign lb0_q = in_range ? lb0_rd : '0;
    assign lb1_q = in_range ? lb1_rd : '0;

    // Next column-shift state and its packed form for the output register.
    always_comb begin
        win_nxt = '0;
        for (int i = 0; i < 3; i++) begin
            sr_nxt[i][0] = sr[i][1];
            sr_nxt[i][1] = sr[i][2];
        end
        sr_nxt[0][2] = lb1_q;
        sr_nxt[1][2] = lb0_q;
        sr_nxt[2][2] = in_data;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_nxt[tap_slot(i, j)*DATA_WIDTH +: DATA_WIDTH] = sr_nxt[i][j];
            end
        end
    end

    always_comb begin
        mark_nxt     = '0;
        mark_nxt.sof = (r == R_TWO) & (c == C_TWO);
        mark_nxt.sol = (c == C_TWO);
        mark_nxt.eol = in_eol;
        mark_nxt.eof = in_eol & in_eof;
    end

    // Position counters; col saturates at MAX_WIDTH so long lines stay out of range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            synced  <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            if (accept & in_sof) begin
                synced <= 1'b1;
            end
            if (live) begin
                if (in_sof) begin
                    col <= C_ONE;
                    row <= '0;
                end else if (in_sol) begin
                    col <= C_ONE;
                    row <= row + R_ONE;
                end else if (col < C_MAX) begin
                    col <= col + C_ONE;
                end
                if (!in_range) begin
                    err_ovf <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    sr[i][j] <= '0;
                end
            end
        end else if (live) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    sr[i][j] <= sr_nxt[i][j];
                end
            end
        end
    end

    // Output register: a new window always wins over a downstream pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_val  <= 1'b0;
            win_data <= '0;
            mark_q   <= '0;
        end else if (emit) begin
            win_val  <= 1'b1;
            win_data <= win_nxt;
            mark_q   <= mark_nxt;
        end else if (win_val & win_rdy) begin
            win_val  <= 1'b0;
            mark_q   <= '0;
        end
    end

    assign win_sof = mark_q.sof;
    assign win_sol = mark_q.sol;
    assign win_eol = mark_q.eol;
    assign win_eof = mark_q.eof;

endmodule

// File: tb/tb_win3x3_gen.sv
// Purpose : self-checking bench for win3x3_gen (MAX_WIDTH=8 build).
// Latency : n/a.
// Backpres: win_rdy driven fixed or with a 1-0-0-1 pattern.
module tb_win3x3_gen;

    localparam int DW   = 8;
    localparam int MAXW = 8;
    localparam int AW   = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_val;
    logic            in_rdy;
    logic [DW-1:0]   in_data;
    logic            in_sof, in_sol, in_eol, in_eof;
    logic            win_val;
    logic            win_rdy;
    logic [9*DW-1:0] win_data;
    logic            win_sof, win_sol, win_eol, win_eof;
    logic            err_ovf;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;

    typedef struct {
        logic [9*DW-1:0] data;
        logic            sof, sol, eol, eof;
    } win_t;

    win_t sb[$];
    win_t rx_log[$];
    win_t got_w;
    win_t exp_w;

    int  rdy_mode  = 0;
    bit  rdy_fixed = 1'b1;
    int  cyc       = 0;
    bit  rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    win3x3_gen #(
        .DATA_WIDTH (DW),
        .MAX_WIDTH  (MAXW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .in_sof   (in_sof),
        .in_sol   (in_sol),
        .in_eol   (in_eol),
        .in_eof   (in_eof),
        .win_val  (win_val),
        .win_rdy  (win_rdy),
        .win_data (win_data),
        .win_sof  (win_sof),
        .win_sol  (win_sol),
        .win_eol  (win_eol),
        .win_eof  (win_eof),
        .err_ovf  (err_ovf)
    );

    always #5 clk = ~clk;

    // Downstream ready generator.
    initial begin
        win_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            win_rdy = (rdy_mode != 0) ? rdy_pat[cyc % 4] : rdy_fixed;
        end
    end

    task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    function automatic logic [DW-1:0] pix(input int base, input int w, input int r, input int c);
        return DW'((base + r * w + c) & 255);
    endfunction

    // Output monitor and scoreboard compare; handshake completes at the next posedge.
    always @(negedge clk) begin
        checks++;
        if (in_rdy !== (!win_val || win_rdy)) begin
            errors++;
            $display("FAIL in_rdy_rel actual=%b expected=%b", in_rdy, (!win_val || win_rdy));
        end
        if (!rst && win_val && win_rdy) begin
            rx_cnt++;
            got_w.data = win_data;
            got_w.sof  = win_sof;
            got_w.sol  = win_sol;
            got_w.eol  = win_eol;
            got_w.eof  = win_eof;
            rx_log.push_back(got_w);
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_window actual=%0h markers=%b%b%b%b required=none",
                         win_data, win_sof, win_sol, win_eol, win_eof);
            end else begin
                exp_w = sb.pop_front();
                if (got_w.data !== exp_w.data || got_w.sof !== exp_w.sof || got_w.sol !== exp_w.sol ||
                    got_w.eol !== exp_w.eol || got_w.eof !== exp_w.eof) begin
                    errors++;
                    $display("FAIL window actual=%0h %b%b%b%b required=%0h %b%b%b%b",
                             got_w.data, got_w.sof, got_w.sol, got_w.eol, got_w.eof,
                             exp_w.data, exp_w.sof, exp_w.sol, exp_w.eol, exp_w.eof);
                end
            end
        end
    end

    // Present one pixel and hold it until accepted. Called at posedge+1.
    task automatic drive_pix(input logic [DW-1:0] d, input bit sof, input bit sol, input bit eol, input bit eof);
        int n;
        in_val  = 1'b1;
        in_data = d;
        in_sof  = sof;
        in_sol  = sol;
        in_eol  = eol;
        in_eof  = eof;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_rdy) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 100) begin
                checks++;
                errors++;
                $display("FAIL drive_timeout actual=stalled required=accept");
                break;
            end
        end
    endtask

    // Drive a WxH frame; the expected windows come straight from frame coordinates.
    task automatic drive_frame(input int w, input int h, input int base, input bit push,
                               input bit ovf_chk, input bit nosof);
        win_t e;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (push && r >= 2 && c >= 2 && c < MAXW) begin
                    e.data = '0;
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e.data[(8 - (i * 3 + j)) * DW +: DW] = pix(base, w, r - 2 + i, c - 2 + j);
                    e.sof = (r == 2 && c == 2);
                    e.sol = (c == 2);
                    e.eol = (c == w - 1);
                    e.eof = (c == w - 1) && (r == h - 1);
                    sb.push_back(e);
                end
                drive_pix(pix(base, w, r, c), (r == 0 && c == 0 && !nosof), (c == 0),
                          (c == w - 1), (c == w - 1 && r == h - 1));
                if (ovf_chk && r == 0 && (c == MAXW - 1 || c == MAXW))
                    chk($sformatf("err_ovf_c%0d", c), 72'(err_ovf), 72'(c >= MAXW));
            end
        end
    endtask

    task automatic drain(input int expn, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout actual=%0d pending required=0", name, sb.size());
            sb.delete();
        end
        repeat (8) @(posedge clk);
        #1;
        chk({name, "_count"}, 72'(rx_cnt), 72'(expn));
        rx_cnt = 0;
    endtask

    typedef struct {
        int w, h, base, rmode, expn;
        bit dr;
    } vec_t;

    typedef struct {
        logic [DW-1:0] p11;
        logic          sof, sol, eol, eof;
    } s1_t;

    vec_t tbl [6];
    s1_t  s1  [4];
    logic [9*DW-1:0] first_win;

    initial begin
        tbl[0] = '{w: 4, h: 4, base: 0,   rmode: 0, expn: 4, dr: 1'b1};
        tbl[1] = '{w: 4, h: 4, base: 0,   rmode: 1, expn: 4, dr: 1'b1};
        tbl[2] = '{w: 5, h: 3, base: 0,   rmode: 0, expn: 0, dr: 1'b0};
        tbl[3] = '{w: 5, h: 3, base: 100, rmode: 0, expn: 6, dr: 1'b1};
        tbl[4] = '{w: 2, h: 5, base: 50,  rmode: 0, expn: 0, dr: 1'b1};
        tbl[5] = '{w: 4, h: 4, base: 7,   rmode: 0, expn: 4, dr: 1'b1};
        s1[0] = '{p11: 8'd5,  sof: 1'b1, sol: 1'b1, eol: 1'b0, eof: 1'b0};
        s1[1] = '{p11: 8'd6,  sof: 1'b0, sol: 1'b0, eol: 1'b1, eof: 1'b0};
        s1[2] = '{p11: 8'd9,  sof: 1'b0, sol: 1'b1, eol: 1'b0, eof: 1'b0};
        s1[3] = '{p11: 8'd10, sof: 1'b0, sol: 1'b0, eol: 1'b1, eof: 1'b1};
        first_win = {8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10};

        rst = 1'b1;
        in_val = 1'b0; in_data = '0;
        in_sof = 1'b0; in_sol = 1'b0; in_eol = 1'b0; in_eof = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_rdy",   72'(in_rdy),  72'(1));
        chk("rst_win_val",  72'(win_val), 72'(0));
        chk("rst_win_data", win_data,     72'(0));
        chk("rst_markers",  72'({win_sof, win_sol, win_eol, win_eof}), 72'(0));
        chk("rst_err_ovf",  72'(err_ovf), 72'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            rdy_mode  = tbl[i].rmode;
            rdy_fixed = 1'b1;
            rx_log.delete();
            drive_frame(tbl[i].w, tbl[i].h, tbl[i].base, 1'b1, 1'b0, 1'b0);
            if (tbl[i].dr) begin
                in_val = 1'b0;
                drain(tbl[i].expn, $sformatf("vec%0d", i));
            end
            if (i <= 1) begin
                chk($sformatf("vec%0d_log_size", i), 72'(rx_log.size()), 72'(4));
                if (rx_log.size() > 0)
                    chk($sformatf("vec%0d_first_win", i), rx_log[0].data, first_win);
                for (int k = 0; k < 4 && k < rx_log.size(); k++) begin
                    chk($sformatf("vec%0d_p11_%0d", i, k), 72'(rx_log[k].data[4*DW +: DW]), 72'(s1[k].p11));
                    chk($sformatf("vec%0d_mark_%0d", i, k),
                        72'({rx_log[k].sof, rx_log[k].sol, rx_log[k].eol, rx_log[k].eof}),
                        72'({s1[k].sof, s1[k].sol, s1[k].eol, s1[k].eof}));
                end
            end
        end
        rdy_mode = 0;

        // Overflow: 10-wide line against an 8-deep buffer, then stickiness.
        chk("ovf_pre", 72'(err_ovf), 72'(0));
        drive_frame(10, 3, 20, 1'b1, 1'b1, 1'b0);
        in_val = 1'b0;
        drain(6, "ovf");
        chk("ovf_set", 72'(err_ovf), 72'(1));
        drive_frame(4, 4, 30, 1'b1, 1'b0, 1'b0);
        in_val = 1'b0;
        drain(4, "ovf_next");
        chk("ovf_sticky", 72'(err_ovf), 72'(1));

        // Reset mid-frame with a window stuck in the output register.
        rdy_fixed = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 11; k++)
            drive_pix(pix(0, 4, k / 4, k % 4), (k == 0), (k % 4 == 0), (k % 4 == 3), 1'b0);
        in_val = 1'b0;
        @(negedge clk);
        chk("pre_rst_win_val", 72'(win_val), 72'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_win_val",  72'(win_val), 72'(0));
        chk("mid_rst_win_data", win_data,     72'(0));
        chk("mid_rst_markers",  72'({win_sof, win_sol, win_eol, win_eof}), 72'(0));
        chk("mid_rst_err_ovf",  72'(err_ovf), 72'(0));
        chk("mid_rst_in_rdy",   72'(in_rdy),  72'(1));
        rdy_fixed = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        // Unsynced 3x3 raster: must be swallowed without output.
        drive_frame(3, 3, 60, 1'b0, 1'b0, 1'b1);
        drive_frame(4, 4, 0, 1'b1, 1'b0, 1'b0);
        in_val = 1'b0;
        rx_log.delete();
        drain(4, "post_rst");
        chk("post_rst_err_ovf", 72'(err_ovf), 72'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule
